// File: rtl/rv32m_divider_if.sv
// Handshake bundle between the ID/EX operand path and the iterative divider.
interface rv32m_divider_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            valid_out;
  logic [XLEN-1:0] result;

  // Pipeline side: issues requests and kills, consumes the result.
  modport master (
    output start, op, rs1, rs2, flush,
    input  busy, valid_out, result
  );

  // Divider side.
  modport slave (
    input  start, op, rs1, rs2, flush,
    output busy, valid_out, result
  );
endinterface

// File: rtl/rv32m_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration loop.
//
// state | meaning
// IDLE  | waiting for start; result_q holds the last completed value
// CALC  | iterating, busy asserted, XLEN cycles
// DONE  | final value ready in fin_q; published with valid_out on exit
module rv32m_divider #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  rv32m_divider_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            sgn_rem_q, sgn_rem_d;
  logic            sgn_quo_q, sgn_quo_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] fin_q, fin_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            valid_q, valid_d;

  logic            is_signed;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   rem_sh, trial;
  logic [XLEN-1:0] rem_nx, quo_nx;

  // One restoring step: shift {rem, quo}, trial-subtract, keep if non-negative.
  always_comb begin
    is_signed = ~bus.op[0];
    a_abs     = (is_signed && bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
    b_abs     = (is_signed && bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;
    rem_sh    = {rem_q, quo_q[XLEN-1]};
    trial     = rem_sh - {1'b0, div_q};
    if (!trial[XLEN]) begin
      rem_nx = trial[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sgn_rem_d = sgn_rem_q;
    sgn_quo_d = sgn_quo_q;
    div_d     = div_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    fin_d     = fin_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d      = bus.op;
          sgn_rem_d = is_signed & bus.rs1[XLEN-1];
          sgn_quo_d = is_signed & (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]);
          div_d     = b_abs;
          quo_d     = a_abs;
          rem_d     = '0;
          cnt_d     = '0;
          if (bus.rs2 == '0) begin
            fin_d   = bus.op[1] ? bus.rs1 : '1;
            state_d = S_DONE;
          end else if (is_signed && bus.rs1 == MIN_NEG && bus.rs2 == '1) begin
            fin_d   = bus.op[1] ? '0 : MIN_NEG;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) begin
            // Sign fix-up: quotient negated on sign mismatch, remainder follows dividend.
            fin_d   = op_q[1] ? (sgn_rem_q ? -rem_nx : rem_nx)
                              : (sgn_quo_q ? -quo_nx : quo_nx);
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // A flush here discards the value; result_q keeps the previous completion.
        state_d = S_IDLE;
        if (!bus.flush) begin
          result_d = fin_q;
          valid_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      sgn_rem_q <= 1'b0;
      sgn_quo_q <= 1'b0;
      div_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      fin_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sgn_rem_q <= sgn_rem_d;
      sgn_quo_q <= sgn_quo_d;
      div_q     <= div_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      fin_q     <= fin_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.busy      = (state_q == S_CALC);
  assign bus.valid_out = valid_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_rv32m_divider.sv
// Self-checking bench for rv32m_divider: scoreboard of expected results,
// latency/busy measurement per operation, flush/reset/start-hold corner cases.
module tb_rv32m_divider;
  logic clk;
  logic rst;

  rv32m_divider_if #(.XLEN(32)) bus_if ();

  rv32m_divider #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_valid  = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  // Scoreboard: every valid_out pulse pops one expected result.
  always @(negedge clk) begin
    if (rst && bus_if.valid_out) begin
      n_valid++;
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(bus_if.valid_out), 32'd0);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("result", bus_if.result, e);
        last_res = e;
      end
    end
  end

  // Issue one op, scoreboard it, and measure busy cycles and valid latency.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit special);
    int nb;
    int lat;
    nb  = 0;
    lat = -1;
    bus_if.op    = op;
    bus_if.rs1   = a;
    bus_if.rs2   = b;
    bus_if.start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.op    = 2'($urandom);
    bus_if.rs1   = $urandom;
    bus_if.rs2   = $urandom;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_if.busy) nb++;
      if (bus_if.valid_out) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), special ? 32'd1 : 32'd33);
    check({tag, "_busy_cycles"}, 32'(nb), special ? 32'd0 : 32'd32);
    @(negedge clk);
    check({tag, "_pulse_width"}, 32'(bus_if.valid_out), 32'd0);
    check({tag, "_result_hold"}, bus_if.result, exp);
  endtask

  initial begin
    int v0;
    int nb;
    rst          = 1'b0;
    bus_if.start = 1'b0;
    bus_if.flush = 1'b0;
    bus_if.op    = 2'b00;
    bus_if.rs1   = '0;
    bus_if.rs2   = '0;
    #12;
    check("reset_busy", 32'(bus_if.busy), 32'd0);
    check("reset_valid", 32'(bus_if.valid_out), 32'd0);
    check("reset_result", bus_if.result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    run_op("div_by0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_op("remu_by0", 2'b11, 32'd5, 32'd0, 32'd5, 1'b1);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    run_op("divu_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("div_zero_dividend", 2'b00, 32'd0, 32'd5, 32'd0, 1'b0);
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);

    // Flush after 10 iterations: no completion, result unchanged, then restart.
    bus_if.op    = 2'b01;
    bus_if.rs1   = 32'd1000;
    bus_if.rs2   = 32'd7;
    bus_if.start = 1'b1;
    v0 = n_valid;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus_if.flush = 1'b1;
    @(posedge clk);
    #1;
    bus_if.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(bus_if.busy), 32'd0);
    check("flush_valid", 32'(bus_if.valid_out), 32'd0);
    check("flush_result", bus_if.result, last_res);
    run_op("divu_9_3_after_flush", 2'b01, 32'd9, 32'd3, 32'd3, 1'b0);
    check("flush_completions", 32'(n_valid - v0), 32'd1);

    // start held through CALC: exactly one completion.
    v0 = n_valid;
    nb = 0;
    bus_if.op    = 2'b01;
    bus_if.rs1   = 32'd100;
    bus_if.rs2   = 32'd7;
    bus_if.start = 1'b1;
    sb.push_back(32'd14);
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_if.busy) nb++;
      else break;
    end
    bus_if.start = 1'b0;
    check("hold_busy_cycles", 32'(nb), 32'd32);
    nb = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.busy) nb++;
    end
    check("hold_completions", 32'(n_valid - v0), 32'd1);
    check("hold_no_restart", 32'(nb), 32'd0);

    // Same-cycle start+flush in IDLE is dropped.
    v0 = n_valid;
    nb = 0;
    bus_if.op    = 2'b00;
    bus_if.rs1   = 32'd5;
    bus_if.rs2   = 32'd3;
    bus_if.start = 1'b1;
    bus_if.flush = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.flush = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.busy) nb++;
    end
    check("startflush_busy", 32'(nb), 32'd0);
    check("startflush_completions", 32'(n_valid - v0), 32'd0);

    // Asynchronous reset mid-CALC.
    bus_if.op    = 2'b01;
    bus_if.rs1   = 32'd100;
    bus_if.rs2   = 32'd7;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("pre_reset_busy", 32'(bus_if.busy), 32'd1);
    rst = 1'b0;
    #1;
    check("async_reset_busy", 32'(bus_if.busy), 32'd0);
    check("async_reset_valid", 32'(bus_if.valid_out), 32'd0);
    check("async_reset_result", bus_if.result, 32'd0);
    last_res = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("divu_after_reset", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0);

    // Random operands against the reference model.
    for (int i = 0; i < 6; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      bit          sp;
      op = 2'($urandom);
      a  = $urandom;
      b  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 3 == 2) b = -b;
      sp = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      run_op("random", op, a, b, model(op, a, b), sp);
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
